// File: rtl/rob.sv
// rtl/rob.sv - in-order reorder buffer: tail allocation, id writeback, head retire, mispredict flush
module rob #(
  parameter int ROB_WIDTH_BIT = 4,
  parameter int ROB_WIDTH     = 1 << ROB_WIDTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  output logic                     rob_full,
  output logic [ROB_WIDTH_BIT-1:0] rob_tail,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_type,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_pred,
  input  logic [31:0]              issue_alt_pc,
  input  logic                     rs_to_rob,
  input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
  input  logic [31:0]              rs_value,
  input  logic [31:0]              rs_new_pc,
  input  logic                     lsb_to_rob,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_value,
  input  logic [ROB_WIDTH_BIT-1:0] qj_id,
  input  logic [ROB_WIDTH_BIT-1:0] qk_id,
  output logic                     qj_rdy,
  output logic                     qk_rdy,
  output logic [31:0]              qj_val,
  output logic [31:0]              qk_val,
  output logic                     commit_reg_en,
  output logic [4:0]               commit_rd,
  output logic [31:0]              commit_value,
  output logic [ROB_WIDTH_BIT-1:0] commit_id,
  output logic                     commit_store,
  output logic                     clear_all,
  output logic [31:0]              new_pc
);

  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_BRANCH = 2'd1;
  localparam logic [1:0] TYPE_JALR   = 2'd2;
  localparam logic [1:0] TYPE_STORE  = 2'd3;
  localparam logic [ROB_WIDTH_BIT:0]   FULL_COUNT = (ROB_WIDTH_BIT + 1)'(ROB_WIDTH);
  localparam logic [ROB_WIDTH_BIT:0]   CNT_ONE    = 1;
  localparam logic [ROB_WIDTH_BIT-1:0] ID_ONE     = 1;

  logic [ROB_WIDTH_BIT-1:0] head;
  logic [ROB_WIDTH_BIT-1:0] tail;
  logic [ROB_WIDTH_BIT:0]   count;

  logic        busy     [ROB_WIDTH];
  logic        ready    [ROB_WIDTH];
  logic [1:0]  ent_type [ROB_WIDTH];
  logic [4:0]  ent_rd   [ROB_WIDTH];
  logic        ent_pred [ROB_WIDTH];
  logic [31:0] ent_alt  [ROB_WIDTH];
  logic [31:0] ent_val  [ROB_WIDTH];

  logic do_issue;
  logic do_commit;
  logic head_redirect;

  assign rob_full      = (count == FULL_COUNT);
  assign rob_tail      = tail;
  // rob_full is the pre-commit occupancy, so a full buffer never issues even while retiring
  assign do_issue      = issue_valid && !rob_full;
  assign do_commit     = busy[head] && ready[head];
  assign head_redirect = (ent_type[head] == TYPE_JALR) ||
                         ((ent_type[head] == TYPE_BRANCH) && (ent_val[head][0] != ent_pred[head]));

  // Operand lookup: same-cycle writebacks bypass storage, RS taking precedence over LSB
  always_comb begin
    qj_rdy = ready[qj_id];
    qj_val = ent_val[qj_id];
    qk_rdy = ready[qk_id];
    qk_val = ent_val[qk_id];
    if (lsb_to_rob && lsb_rob_id == qj_id) begin qj_rdy = 1'b1; qj_val = lsb_value; end
    if (rs_to_rob  && rs_rob_id  == qj_id) begin qj_rdy = 1'b1; qj_val = rs_value;  end
    if (lsb_to_rob && lsb_rob_id == qk_id) begin qk_rdy = 1'b1; qk_val = lsb_value; end
    if (rs_to_rob  && rs_rob_id  == qk_id) begin qk_rdy = 1'b1; qk_val = rs_value;  end
  end

  // Queue state, writebacks, retirement and registered commit/flush outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_reg_en <= 1'b0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_id     <= '0;
      commit_store  <= 1'b0;
      clear_all     <= 1'b0;
      new_pc        <= '0;
      for (int i = 0; i < ROB_WIDTH; i++) begin
        busy[i]  <= 1'b0;
        ready[i] <= 1'b0;
      end
    end else if (!rdy_in) begin
      commit_reg_en <= 1'b0;
      commit_store  <= 1'b0;
      clear_all     <= 1'b0;
    end else begin
      commit_reg_en <= 1'b0;
      commit_store  <= 1'b0;
      clear_all     <= 1'b0;
      if (do_commit) begin
        commit_rd     <= ent_rd[head];
        commit_value  <= ent_val[head];
        commit_id     <= head;
        commit_reg_en <= ((ent_type[head] == TYPE_REG) || (ent_type[head] == TYPE_JALR)) &&
                         (ent_rd[head] != 5'd0);
        commit_store  <= (ent_type[head] == TYPE_STORE);
        if (head_redirect) begin
          clear_all <= 1'b1;
          new_pc    <= ent_alt[head];
        end
      end
      if (do_commit && head_redirect) begin
        // Redirect drops every in-flight entry, including this cycle's issue and writebacks
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < ROB_WIDTH; i++) begin
          busy[i]  <= 1'b0;
          ready[i] <= 1'b0;
        end
      end else begin
        if (lsb_to_rob && busy[lsb_rob_id]) begin
          ready[lsb_rob_id] <= 1'b1;
          if (ent_type[lsb_rob_id] != TYPE_STORE) ent_val[lsb_rob_id] <= lsb_value;
        end
        if (rs_to_rob && busy[rs_rob_id]) begin
          ready[rs_rob_id]   <= 1'b1;
          ent_val[rs_rob_id] <= rs_value;
          if (ent_type[rs_rob_id] == TYPE_JALR) ent_alt[rs_rob_id] <= rs_new_pc;
        end
        if (do_issue) begin
          busy[tail]     <= 1'b1;
          ready[tail]    <= 1'b0;
          ent_type[tail] <= issue_type;
          ent_rd[tail]   <= issue_rd;
          ent_pred[tail] <= issue_pred;
          ent_alt[tail]  <= issue_alt_pc;
          tail           <= tail + ID_ONE;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + ID_ONE;
        end
        if (do_issue && !do_commit)      count <= count + CNT_ONE;
        else if (!do_issue && do_commit) count <= count - CNT_ONE;
      end
    end
  end

endmodule
